rs_simple_station: RTL and testbench
====================================

// Module: rs_simple_station
// PURPOSE
//  Two-entry reservation station for the "simple" FU, directly upstream of ex_simple.
//  - Accepts one dispatched instruction per cycle.
//  - Holds its operands and captures missing operands from two result-broadcast buses.
//  - Presents both entries to ex_simple in its 77-bit entry format, plus an age selector.
//  - Frees an entry on the cycle ex_simple reports it issued.
// PARAMETERS
//  TAG_W    5   producer tag width (destination register address on broadcast buses)
//  ENTRY_W  77  entry width: {RFwrite, rs2_val, rs2_v, rs1_val, rs1_v, rd, aluop}
// PORTS
//  clk             in   1    clock, rising edge
//  rst_n           in   1    asynchronous, active-low reset
//  flush           in   1    synchronous clear of both entries (branch recovery)
//  disp_valid      in   1    dispatch request
//  disp_ready      out  1    at least one entry free (registered state only)
//  disp_entry      in   77   entry in ENTRY_W format; see operand tag encoding below
//  wb0_en          in   1    broadcast bus 0 valid (ex_simple writeEn)
//  wb0_tag         in   5    broadcast bus 0 destination register
//  wb0_data        in   32   broadcast bus 0 value
//  wb1_en          in   1    broadcast bus 1 valid (other FU)
//  wb1_tag         in   5    broadcast bus 1 destination register
//  wb1_data        in   32   broadcast bus 1 value
//  simple_0_issue  in   1    ex_simple consumed entry 0 this cycle
//  simple_1_issue  in   1    ex_simple consumed entry 1 this cycle
//  rs_simple_0     out  77   entry 0 to ex_simple; all zero when empty
//  rs_simple_1     out  77   entry 1 to ex_simple; all zero when empty
//  selector        out  1    1: entry 0 is older; 0: entry 1 is older or only one entry occupied
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - Both entries empty; rs_simple_0/1 = 0; selector = 0; disp_ready = 1.
//  Operand encoding:
//   - Operand valid bit (bit 10 for rs1, bit 43 for rs2) = 1: field holds the value.
//   - Valid bit = 0: field[4:0] holds the producer tag; field[31:5] = 0.
//  Dispatch:
//   - Occurs when disp_valid & disp_ready.
//   - Writes the lowest-index empty entry at the next edge.
//   - Free-entry state is sampled at the start of the cycle; a slot freed by issue in the same cycle is not reused until the next cycle.
//  Wakeup, per stored or incoming operand with valid bit = 0:
//   - Match when wbN_en = 1 and wbN_tag equals the stored tag.
//   - On a match, load wbN_data and set the valid bit at the next edge.
//   - If both buses match, wb0 wins.
//   - Operands with valid bit = 1 are never overwritten.
//   - Dispatched operands are compared against the buses in the same cycle, so there is no lost wakeup.
//  Issue:
//   - simple_X_issue = 1 empties entry X at the next edge.
//   - Issue of an entry beats a same-cycle wakeup of that entry.
//   - Both issue inputs asserted in one cycle are illegal; the bench asserts on this.
//  Age:
//   - Register old0 = entry 0 older.
//   - Dispatch into entry 1 while entry 0 is occupied sets old0 = 1.
//   - Dispatch into entry 0 while entry 1 is occupied clears old0.
//   - selector = old0 & both occupied.
//  Outputs:
//   - rs_simple_* are direct register outputs, zero-latency to ex_simple.
//   - An entry is visible the cycle after dispatch.
//  Flush:
//   - Empties both entries at the next edge and clears old0.
//   - Overrides a same-cycle dispatch, issue and wakeup.
//  Reset mid-operation:
//   - Immediate return to reset values; pending entries are discarded.
//  Width rules:
//   - Tag compare uses [4:0] only.
//   - aluop, rd and RFwrite pass through unchanged.
// TESTING
//  1. Reset, then dispatch an entry with both operands valid (rs1=5, rs2=7, rd=3, aluop=0):
//     - next cycle rs_simple_0 has bits 10 and 43 set;
//     - issue -> entry 0 = 0 the cycle after.
//  2. Dispatch with rs1 waiting on tag 9; later wb1_en=1, wb1_tag=9, wb1_data=0xDEADBEEF:
//     - the following cycle rs_simple_0[42:11] = 0xDEADBEEF and bit 10 = 1.
//  3. Dispatch in the same cycle as wb0 broadcasts tag 4 = 0x11, with rs2 waiting on tag 4:
//     - entry appears with rs2 = 0x11, valid.
//  4. Fill both entries (entry 0 first):
//     - disp_ready = 0 and selector = 1;
//     - issue entry 0, then dispatch a new entry -> it lands in entry 0 and selector = 0.
//  5. Both buses broadcast tag 6 (wb0 = 1, wb1 = 2) to a waiting operand -> captured value = 1.
//  6. flush with both entries occupied plus a dispatch in the same cycle:
//     - both outputs = 0 and disp_ready = 1 the next cycle;
//     - rst_n pulsed mid-wakeup -> outputs zero immediately.

Source files
------------

// File: rtl/rs_simple_station.sv
// Two-entry reservation station feeding ex_simple: holds dispatched instructions,
// captures missing operands from two result buses, and frees entries on issue.
module rs_simple_station #(
    parameter int TAG_W   = 5,
    parameter int ENTRY_W = 77
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic [ENTRY_W-1:0] disp_entry,
    input  logic               wb0_en,
    input  logic [TAG_W-1:0]   wb0_tag,
    input  logic [31:0]        wb0_data,
    input  logic               wb1_en,
    input  logic [TAG_W-1:0]   wb1_tag,
    input  logic [31:0]        wb1_data,
    input  logic               simple_0_issue,
    input  logic               simple_1_issue,
    output logic [ENTRY_W-1:0] rs_simple_0,
    output logic [ENTRY_W-1:0] rs_simple_1,
    output logic               selector
);

    // Operand slices are {value[31:0], valid}: rs1 at [42:10], rs2 at [75:43].
    localparam int RS1_LSB = 10;
    localparam int RS2_LSB = 43;
    localparam int OP_W    = 33;

    logic [ENTRY_W-1:0] ent_q [2];
    logic [ENTRY_W-1:0] ent_d [2];
    logic [1:0]         occ_q, occ_d;
    logic               old0_q, old0_d;
    logic               do_disp;
    logic               disp_slot;
    logic [1:0]         issue;

    // A waiting operand takes the first matching bus value; wb0 has priority.
    function automatic logic [OP_W-1:0] wake_op(
        input logic [OP_W-1:0]  op,
        input logic             e0,
        input logic [TAG_W-1:0] t0,
        input logic [31:0]      d0,
        input logic             e1,
        input logic [TAG_W-1:0] t1,
        input logic [31:0]      d1
    );
        logic [OP_W-1:0] r;
        r = op;
        if (!op[0]) begin
            if (e0 && (op[TAG_W:1] == t0)) begin
                r = {d0, 1'b1};
            end else if (e1 && (op[TAG_W:1] == t1)) begin
                r = {d1, 1'b1};
            end
        end
        return r;
    endfunction

    function automatic logic [ENTRY_W-1:0] wake_entry(
        input logic [ENTRY_W-1:0] e,
        input logic               e0,
        input logic [TAG_W-1:0]   t0,
        input logic [31:0]        d0,
        input logic               e1,
        input logic [TAG_W-1:0]   t1,
        input logic [31:0]        d1
    );
        logic [ENTRY_W-1:0] r;
        r = e;
        r[RS1_LSB +: OP_W] = wake_op(e[RS1_LSB +: OP_W], e0, t0, d0, e1, t1, d1);
        r[RS2_LSB +: OP_W] = wake_op(e[RS2_LSB +: OP_W], e0, t0, d0, e1, t1, d1);
        return r;
    endfunction

    assign issue      = {simple_1_issue, simple_0_issue};
    assign disp_ready = ~(occ_q[0] & occ_q[1]);
    assign do_disp    = disp_valid & disp_ready;
    assign disp_slot  = occ_q[0];

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        occ_d  = occ_q;
        old0_d = old0_q;
        for (int i = 0; i < 2; i++) begin
            ent_d[i] = occ_q[i] ? wake_entry(ent_q[i], wb0_en, wb0_tag, wb0_data,
                                             wb1_en, wb1_tag, wb1_data)
                                : '0;
            if (issue[i]) begin
                occ_d[i] = 1'b0;
                ent_d[i] = '0;
            end
        end

        // Target slot is empty in registered state, so an issue cannot collide with it.
        if (do_disp) begin
            occ_d[disp_slot] = 1'b1;
            ent_d[disp_slot] = wake_entry(disp_entry, wb0_en, wb0_tag, wb0_data,
                                          wb1_en, wb1_tag, wb1_data);
            if (disp_slot && occ_q[0]) begin
                old0_d = 1'b1;
            end else if (!disp_slot && occ_q[1]) begin
                old0_d = 1'b0;
            end
        end

        if (flush) begin
            occ_d    = '0;
            old0_d   = 1'b0;
            ent_d[0] = '0;
            ent_d[1] = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= '0;
            old0_q   <= 1'b0;
            ent_q[0] <= '0;
            ent_q[1] <= '0;
        end else begin
            occ_q    <= occ_d;
            old0_q   <= old0_d;
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
        end
    end

    assign rs_simple_0 = ent_q[0];
    assign rs_simple_1 = ent_q[1];
    assign selector    = old0_q & occ_q[0] & occ_q[1];

endmodule

// File: tb/tb_rs_simple_station.sv
// Directed self-checking bench for rs_simple_station: dispatch, wakeup, issue, age, flush, reset.
module tb_rs_simple_station;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [76:0] disp_entry;
    logic        wb0_en;
    logic [4:0]  wb0_tag;
    logic [31:0] wb0_data;
    logic        wb1_en;
    logic [4:0]  wb1_tag;
    logic [31:0] wb1_data;
    logic        simple_0_issue;
    logic        simple_1_issue;
    logic [76:0] rs_simple_0;
    logic [76:0] rs_simple_1;
    logic        selector;

    int n_checks = 0;
    int n_fail   = 0;

    rs_simple_station dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_entry     (disp_entry),
        .wb0_en         (wb0_en),
        .wb0_tag        (wb0_tag),
        .wb0_data       (wb0_data),
        .wb1_en         (wb1_en),
        .wb1_tag        (wb1_tag),
        .wb1_data       (wb1_data),
        .simple_0_issue (simple_0_issue),
        .simple_1_issue (simple_1_issue),
        .rs_simple_0    (rs_simple_0),
        .rs_simple_1    (rs_simple_1),
        .selector       (selector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // The two issue inputs must never be asserted together.
    always @(posedge clk) begin
        if (rst_n) begin
            n_checks++;
            assert (!(simple_0_issue && simple_1_issue)) else begin
                n_fail++;
                $error("FAIL double_issue: observed 1 expected 0");
            end
        end
    end

    task automatic check(input string tag, input logic [76:0] obs, input logic [76:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [76:0] mk(input logic rfw, input logic v2, input logic [31:0] f2,
                                       input logic v1, input logic [31:0] f1,
                                       input logic [4:0] rd, input logic [4:0] op);
        return {rfw, f2, v2, f1, v1, rd, op};
    endfunction

    logic [76:0] e;

    initial begin
        rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_entry = '0;
        wb0_en = 1'b0; wb0_tag = '0; wb0_data = '0;
        wb1_en = 1'b0; wb1_tag = '0; wb1_data = '0;
        simple_0_issue = 1'b0; simple_1_issue = 1'b0;
        #3;
        check("rst_rs0",   rs_simple_0, '0);
        check("rst_rs1",   rs_simple_1, '0);
        check("rst_sel",   {76'd0, selector}, 77'd0);
        check("rst_ready", {76'd0, disp_ready}, 77'd1);
        tick();
        rst_n = 1'b1;

        // 1: both operands ready, then issue
        e = mk(1'b1, 1'b1, 32'd7, 1'b1, 32'd5, 5'd3, 5'd0);
        disp_valid = 1'b1; disp_entry = e;
        tick();
        disp_valid = 1'b0;
        check("t1_entry", rs_simple_0, e);
        check("t1_valid_bits", {75'd0, rs_simple_0[43], rs_simple_0[10]}, 77'd3);
        check("t1_rs1_empty", rs_simple_1, '0);
        simple_0_issue = 1'b1;
        tick();
        simple_0_issue = 1'b0;
        check("t1_issued", rs_simple_0, '0);
        check("t1_ready", {76'd0, disp_ready}, 77'd1);

        // 2: rs1 waits on tag 9, woken by wb1
        e = mk(1'b1, 1'b1, 32'd3, 1'b0, 32'd9, 5'd4, 5'd1);
        disp_valid = 1'b1; disp_entry = e;
        tick();
        disp_valid = 1'b0;
        check("t2_waiting", rs_simple_0, e);
        wb1_en = 1'b1; wb1_tag = 5'd9; wb1_data = 32'hDEADBEEF;
        tick();
        wb1_en = 1'b0;
        check("t2_rs1_val", {45'd0, rs_simple_0[42:11]}, {45'd0, 32'hDEADBEEF});
        check("t2_rs1_v", {76'd0, rs_simple_0[10]}, 77'd1);
        check("t2_entry", rs_simple_0, mk(1'b1, 1'b1, 32'd3, 1'b1, 32'hDEADBEEF, 5'd4, 5'd1));
        wb0_en = 1'b1; wb0_tag = 5'd9; wb0_data = 32'h12345678;
        tick();
        wb0_en = 1'b0;
        check("t2_no_overwrite", rs_simple_0, mk(1'b1, 1'b1, 32'd3, 1'b1, 32'hDEADBEEF, 5'd4, 5'd1));
        simple_0_issue = 1'b1;
        tick();
        simple_0_issue = 1'b0;
        check("t2_issued", rs_simple_0, '0);

        // 3: same-cycle wakeup of a dispatched operand
        e = mk(1'b0, 1'b0, 32'd4, 1'b1, 32'h55, 5'd7, 5'd2);
        disp_valid = 1'b1; disp_entry = e;
        wb0_en = 1'b1; wb0_tag = 5'd4; wb0_data = 32'h11;
        tick();
        disp_valid = 1'b0; wb0_en = 1'b0;
        check("t3_bypass", rs_simple_0, mk(1'b0, 1'b1, 32'h11, 1'b1, 32'h55, 5'd7, 5'd2));

        // 4: fill both, age, slot reuse
        e = mk(1'b1, 1'b1, 32'd1, 1'b1, 32'd2, 5'd8, 5'd3);
        disp_valid = 1'b1; disp_entry = e;
        tick();
        check("t4_entry1", rs_simple_1, e);
        check("t4_full", {76'd0, disp_ready}, 77'd0);
        check("t4_sel_old0", {76'd0, selector}, 77'd1);
        disp_entry = mk(1'b1, 1'b1, 32'd9, 1'b1, 32'd10, 5'd11, 5'd4);
        simple_0_issue = 1'b1;
        tick();
        simple_0_issue = 1'b0;
        check("t4_no_reuse", rs_simple_0, '0);
        check("t4_keep1", rs_simple_1, e);
        check("t4_ready", {76'd0, disp_ready}, 77'd1);
        check("t4_sel_single", {76'd0, selector}, 77'd0);
        tick();
        disp_valid = 1'b0;
        check("t4_land0", rs_simple_0, mk(1'b1, 1'b1, 32'd9, 1'b1, 32'd10, 5'd11, 5'd4));
        check("t4_sel_old1", {76'd0, selector}, 77'd0);
        check("t4_full2", {76'd0, disp_ready}, 77'd0);

        // 6a: flush with both occupied, plus dispatch/issue/wakeup
        flush = 1'b1; disp_valid = 1'b1; disp_entry = mk(1'b1, 1'b1, 32'd1, 1'b1, 32'd1, 5'd1, 5'd1);
        simple_1_issue = 1'b1; wb0_en = 1'b1; wb0_tag = 5'd1;
        tick();
        flush = 1'b0; disp_valid = 1'b0; simple_1_issue = 1'b0; wb0_en = 1'b0;
        check("t6_flush0", rs_simple_0, '0);
        check("t6_flush1", rs_simple_1, '0);
        check("t6_ready", {76'd0, disp_ready}, 77'd1);
        check("t6_sel", {76'd0, selector}, 77'd0);

        // 5: both buses match; wb0 wins
        e = mk(1'b0, 1'b0, 32'd6, 1'b1, 32'd3, 5'd2, 5'd5);
        disp_valid = 1'b1; disp_entry = e;
        tick();
        disp_valid = 1'b0;
        wb0_en = 1'b1; wb0_tag = 5'd6; wb0_data = 32'd1;
        wb1_en = 1'b1; wb1_tag = 5'd6; wb1_data = 32'd2;
        tick();
        wb0_en = 1'b0; wb1_en = 1'b0;
        check("t5_wb0_wins", rs_simple_0, mk(1'b0, 1'b1, 32'd1, 1'b1, 32'd3, 5'd2, 5'd5));

        // 6b: async reset during a pending wakeup
        disp_valid = 1'b1; disp_entry = mk(1'b1, 1'b1, 32'd4, 1'b0, 32'd13, 5'd9, 5'd6);
        tick();
        disp_valid = 1'b0;
        check("t6_sel_before", {76'd0, selector}, 77'd1);
        wb0_en = 1'b1; wb0_tag = 5'd13; wb0_data = 32'hCAFE;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rs0", rs_simple_0, '0);
        check("t6_rst_rs1", rs_simple_1, '0);
        check("t6_rst_sel", {76'd0, selector}, 77'd0);
        check("t6_rst_ready", {76'd0, disp_ready}, 77'd1);
        #1;
        rst_n = 1'b1;
        tick();
        wb0_en = 1'b0;
        check("t6_after_rst0", rs_simple_0, '0);
        check("t6_after_rst1", rs_simple_1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
